// File: rtl/lights_off_status_if.sv
// ---------------------------------------------------------------------------
// lights_off_status_if
//   Groups the signals between the lights_off game core, the status stage and
//   the HEX3..HEX0 display pins.
//
//   lights        game core -> status  10-bit board, 1 = lamp on
//   move_stb      game core -> status  one-cycle pulse, a move was applied
//   new_game_stb  game core -> status  one-cycle pulse, a puzzle was loaded
//   won           status -> outside    1 while the solved board is shown
//   moves_bcd     status -> outside    {hundreds,tens,ones} BCD move count
//   hex3..hex0    status -> pins       {a,b,c,d,e,f,g}, active-low, hex3 left
//
//   master : the side that drives the game strobes and reads the status
//   slave  : the status stage itself
// ---------------------------------------------------------------------------
interface lights_off_status_if;
  logic [9:0]  lights;
  logic        move_stb;
  logic        new_game_stb;
  logic        won;
  logic [11:0] moves_bcd;
  logic [6:0]  hex3;
  logic [6:0]  hex2;
  logic [6:0]  hex1;
  logic [6:0]  hex0;

  modport master (
    output lights, move_stb, new_game_stb,
    input  won, moves_bcd, hex3, hex2, hex1, hex0
  );

  modport slave (
    input  lights, move_stb, new_game_stb,
    output won, moves_bcd, hex3, hex2, hex1, hex0
  );
endinterface

// File: rtl/lights_off_status.sv
// ---------------------------------------------------------------------------
// lights_off_status
//   Status stage behind the lights_off game core. Counts moves in BCD,
//   detects the solved (all lamps off) board and drives four active-low
//   7-segment digits: dashes before the first game, blank + move count while
//   playing, 'F' + move count once solved.
//
// Parameters
//   BLINK_DIV  width of the win-blink counter; digits blank while its MSB = 1
//   MAX_MOVES  decimal saturation value of the move counter (<= 999)
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    lights_off_status_if.slave (board, strobes, won, count, hex digits)
//
// Build option
//   LIGHTS_OFF_STATUS_BLINK_EN : when defined, the count digits blink while
//   the board is solved; otherwise the solved display is steady and no blink
//   counter exists.
// ---------------------------------------------------------------------------
module lights_off_status #(
  parameter int BLINK_DIV = 24,
  parameter int MAX_MOVES = 999
) (
  input  logic                clk,
  input  logic                rst_n,
  lights_off_status_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2
  } state_t;

  localparam logic [11:0] MAX_BCD = {4'(MAX_MOVES / 100),
                                     4'((MAX_MOVES / 10) % 10),
                                     4'(MAX_MOVES % 10)};

  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  state_t      state;
  state_t      state_next;
  logic [11:0] moves;
  logic [11:0] moves_next;
  logic [11:0] moves_inc;
  logic        blink_blank;
  logic [6:0]  hex3_next;
  logic [6:0]  hex2_next;
  logic [6:0]  hex1_next;
  logic [6:0]  hex0_next;

  function automatic logic [6:0] seg(input logic [3:0] digit);
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  // BCD increment with carry from ones into tens into hundreds.
  always_comb begin
    moves_inc = moves;
    if (moves[3:0] == 4'd9) begin
      moves_inc[3:0] = 4'd0;
      if (moves[7:4] == 4'd9) begin
        moves_inc[7:4]  = 4'd0;
        moves_inc[11:8] = moves[11:8] + 4'd1;
      end else begin
        moves_inc[7:4] = moves[7:4] + 4'd1;
      end
    end else begin
      moves_inc[3:0] = moves[3:0] + 4'd1;
    end
  end

  // New game beats a simultaneous move. The win test uses the count as it
  // stands before this cycle's move, so a move that also clears the board
  // wins one cycle later, and an already-clear puzzle at 000 never wins.
  always_comb begin
    state_next = state;
    moves_next = moves;
    case (state)
      IDLE: begin
        if (bus.new_game_stb) begin
          state_next = PLAY;
          moves_next = 12'h000;
        end
      end
      PLAY: begin
        if (bus.new_game_stb) begin
          moves_next = 12'h000;
        end else begin
          if (bus.move_stb && (moves != MAX_BCD)) begin
            moves_next = moves_inc;
          end
          if ((bus.lights == 10'b0) && (moves != 12'h000)) begin
            state_next = WON;
          end
        end
      end
      WON: begin
        if (bus.new_game_stb) begin
          state_next = PLAY;
          moves_next = 12'h000;
        end
      end
      default: begin
        state_next = IDLE;
        moves_next = 12'h000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      moves <= 12'h000;
    end else begin
      state <= state_next;
      moves <= moves_next;
    end
  end

`ifdef LIGHTS_OFF_STATUS_BLINK_EN
  logic [BLINK_DIV-1:0] blink_ctr;

  // Runs only while staying in WON; the first WON cycle therefore sees 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_ctr <= '0;
    end else if ((state == WON) && (state_next == WON)) begin
      blink_ctr <= blink_ctr + BLINK_DIV'(1);
    end else begin
      blink_ctr <= '0;
    end
  end

  assign blink_blank = blink_ctr[BLINK_DIV-1];
`else
  // Steady display: a counter narrower than one bit can never reach its MSB.
  assign blink_blank = (BLINK_DIV < 1);
`endif

  always_comb begin
    hex3_next = SEG_DASH;
    hex2_next = SEG_DASH;
    hex1_next = SEG_DASH;
    hex0_next = SEG_DASH;
    case (state)
      PLAY: begin
        hex3_next = SEG_BLANK;
        hex2_next = seg(moves[11:8]);
        hex1_next = seg(moves[7:4]);
        hex0_next = seg(moves[3:0]);
      end
      WON: begin
        hex3_next = SEG_F;
        if (blink_blank) begin
          hex2_next = SEG_BLANK;
          hex1_next = SEG_BLANK;
          hex0_next = SEG_BLANK;
        end else begin
          hex2_next = seg(moves[11:8]);
          hex1_next = seg(moves[7:4]);
          hex0_next = seg(moves[3:0]);
        end
      end
      default: begin
        hex3_next = SEG_DASH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.hex3 <= SEG_DASH;
      bus.hex2 <= SEG_DASH;
      bus.hex1 <= SEG_DASH;
      bus.hex0 <= SEG_DASH;
    end else begin
      bus.hex3 <= hex3_next;
      bus.hex2 <= hex2_next;
      bus.hex1 <= hex1_next;
      bus.hex0 <= hex0_next;
    end
  end

  assign bus.won       = (state == WON);
  assign bus.moves_bcd = moves;

endmodule

// File: tb/tb_lights_off_status.sv
// ---------------------------------------------------------------------------
// tb_lights_off_status
//   Drives lights_off_status with directed scenarios and random game traffic
//   and compares every cycle against a reference model that keeps the move
//   count as a plain integer and the game phase as a small enumerated mode.
//   Works with or without LIGHTS_OFF_STATUS_BLINK_EN defined.
// ---------------------------------------------------------------------------
module tb_lights_off_status;

  localparam int BLINK_DIV = 4;
  localparam int MAX_MOVES = 999;
  localparam int HALF_BLINK = 2 ** (BLINK_DIV - 1);

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_WON  = 2;

  logic clk;
  logic rst_n;
  int   num_checks;
  int   num_errors;

  // Reference model state
  int         m_mode;
  int         m_moves;
  int         m_age;
  logic [27:0] e_disp;

  logic [6:0] seg_tab [10];

  lights_off_status_if bus ();

  lights_off_status #(
    .BLINK_DIV (BLINK_DIV),
    .MAX_MOVES (MAX_MOVES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    to_bcd = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Display that the given game situation should put on the pins.
  function automatic logic [27:0] disp(input int mode, input int n, input int age);
    logic [6:0] d2, d1, d0;
    d2 = seg_tab[n / 100];
    d1 = seg_tab[(n / 10) % 10];
    d0 = seg_tab[n % 10];
    if (mode == M_IDLE) begin
      disp = {4{7'b1111110}};
    end else if (mode == M_PLAY) begin
      disp = {7'b1111111, d2, d1, d0};
    end else begin
`ifdef LIGHTS_OFF_STATUS_BLINK_EN
      if (((age / HALF_BLINK) % 2) == 1)
        disp = {7'b0111000, {3{7'b1111111}}};
      else
        disp = {7'b0111000, d2, d1, d0};
`else
      disp = {7'b0111000, d2, d1, d0};
`endif
    end
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".won"},   32'(bus.won),       32'(m_mode == M_WON));
    checkOutput({tag, ".moves"}, 32'(bus.moves_bcd), 32'(to_bcd(m_moves)));
    checkOutput({tag, ".hex"},   32'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'(e_disp));
  endtask

  task automatic modelReset();
    m_mode  = M_IDLE;
    m_moves = 0;
    m_age   = 0;
    e_disp  = {4{7'b1111110}};
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 later.
  task automatic applyStimulus(input logic ms, input logic ng, input logic [9:0] lt,
                               input string tag);
    int n_mode;
    int n_moves;
    bus.move_stb     = ms;
    bus.new_game_stb = ng;
    bus.lights       = lt;
    @(posedge clk);
    e_disp  = disp(m_mode, m_moves, m_age);
    n_mode  = m_mode;
    n_moves = m_moves;
    if (ng) begin
      n_mode  = M_PLAY;
      n_moves = 0;
    end else if (m_mode == M_PLAY) begin
      if (ms && m_moves < MAX_MOVES) n_moves = m_moves + 1;
      if (lt == 10'b0 && m_moves != 0) n_mode = M_WON;
    end
    m_age   = (n_mode == M_WON && m_mode == M_WON) ? m_age + 1 : 0;
    m_mode  = n_mode;
    m_moves = n_moves;
    #1;
    checkAll(tag);
  endtask

  task automatic doReset(input string tag);
    bus.move_stb     = 1'b0;
    bus.new_game_stb = 1'b0;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll({tag, ".async"});
    repeat (2) @(posedge clk);
    #1;
    checkAll({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] lt;
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    num_checks = 0;
    num_errors = 0;
    bus.lights = 10'h3ff;
    bus.move_stb = 1'b0;
    bus.new_game_stb = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    doReset("por");

    // Strobes before any game are ignored
    repeat (3) applyStimulus(1'b1, 1'b0, 10'h155, "idle_move");

    // Reset in the middle of a game with 12 moves
    applyStimulus(1'b0, 1'b1, 10'b0111111110, "ng1");
    repeat (12) applyStimulus(1'b1, 1'b0, 10'b0111111110, "mv12");
    checkOutput("moves_012", 32'(bus.moves_bcd), 32'h012);
    doReset("midplay");
    repeat (4) applyStimulus(1'b1, 1'b0, 10'h0f0, "after_rst_move");

    // BCD carry 009 -> 010 and its display one cycle later
    applyStimulus(1'b0, 1'b1, 10'b0111111110, "ng2");
    repeat (9) applyStimulus(1'b1, 1'b0, 10'b0111111110, "mv9");
    checkOutput("moves_009", 32'(bus.moves_bcd), 32'h009);
    applyStimulus(1'b1, 1'b0, 10'b0111111110, "mv10");
    checkOutput("moves_010", 32'(bus.moves_bcd), 32'h010);
    applyStimulus(1'b0, 1'b0, 10'b0111111110, "hold10");
    checkOutput("hex_010", 32'({bus.hex2, bus.hex1, bus.hex0}),
                32'({7'b0000001, 7'b1001111, 7'b0000001}));

    // Solve at 003, then moves are frozen; long stay exercises the blink
    applyStimulus(1'b0, 1'b1, 10'h00c, "ng3");
    repeat (3) applyStimulus(1'b1, 1'b0, 10'h00c, "mv3");
    applyStimulus(1'b0, 1'b0, 10'h000, "solve");
    checkOutput("won_003", 32'(bus.won), 32'd1);
    applyStimulus(1'b1, 1'b0, 10'h000, "won_disp");
    checkOutput("hex3_F", 32'(bus.hex3), 32'(7'b0111000));
    repeat (40) applyStimulus(1'b1, 1'b0, 10'h000, "won_frozen");
    checkOutput("won_moves_003", 32'(bus.moves_bcd), 32'h003);

    // Clear board at load does not win; the first move does, one cycle late
    applyStimulus(1'b0, 1'b1, 10'h000, "ng4");
    repeat (20) applyStimulus(1'b0, 1'b0, 10'h000, "zero_wait");
    checkOutput("no_win_000", 32'(bus.won), 32'd0);
    applyStimulus(1'b1, 1'b0, 10'h000, "mv_at_zero");
    checkOutput("no_win_same", 32'(bus.won), 32'd0);
    applyStimulus(1'b0, 1'b0, 10'h000, "win_late");
    checkOutput("win_late", 32'(bus.won), 32'd1);

    // Saturation at 999, then new game beats a simultaneous move
    applyStimulus(1'b0, 1'b1, 10'h200, "ng5");
    repeat (1000) applyStimulus(1'b1, 1'b0, 10'h200, "mv1000");
    checkOutput("moves_999", 32'(bus.moves_bcd), 32'h999);
    applyStimulus(1'b1, 1'b1, 10'h200, "ng_and_mv");
    checkOutput("ng_prio", 32'(bus.moves_bcd), 32'h000);

    // Random game traffic
    for (int i = 0; i < 3000; i++) begin
      lt = ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom_range(1, 1023));
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0), lt, "rand");
      if ($urandom_range(0, 999) == 0) begin
        #2;
        doReset("rand_rst");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
